// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   InstrW   : instruction / PC width
//   PcStep   : byte distance between consecutive instructions
//   fetch_state_e : fetch FSM states (waiting on memory, buffer full, discarding a stale reply)
//   align_pc : clears bit 0 so every PC is halfword aligned
package if_fetch_unit_pkg;

  localparam int unsigned InstrW = 16;
  localparam logic [InstrW-1:0] PcStep = 16'd2;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StFull = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  function automatic logic [InstrW-1:0] align_pc(input logic [InstrW-1:0] pc);
    return {pc[InstrW-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 16-bit pipeline, feeding the IF/ID register.
// Holds the PC, fetches over a req/rvalid handshake, buffers one instruction and
// discards in-flight fetches made stale by a branch redirect.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   freeze                 : IF/ID is not sampling this cycle
//   br_taken, br_target    : redirect request and target (bit 0 ignored)
//   imem_req, imem_addr    : fetch request, held until imem_rvalid
//   imem_rvalid, imem_rdata: fetch response
//   pc_out, pc2_out        : PC of buffered instruction and PC+2
//   IR_out, if_valid       : buffered instruction (NOP_IR when empty) and its valid flag
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] pc2_out,
  output logic [15:0] IR_out,
  output logic        if_valid
);

  localparam logic [15:0] ResetPc = {RESET_PC[15:1], 1'b0};

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  req_addr_q, req_addr_d;
  logic [15:0]  ibuf_q, ibuf_d;
  logic [15:0]  ibuf_pc_q, ibuf_pc_d;
  logic         ibuf_valid_q, ibuf_valid_d;
  logic [15:0]  target;

  assign target = align_pc(br_target);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    ibuf_d       = ibuf_q;
    ibuf_pc_d    = ibuf_pc_q;
    ibuf_valid_d = ibuf_valid_q;

    unique case (state_q)
      StWait: begin
        if (br_taken) begin
          ibuf_valid_d = 1'b0;
          pc_d         = target;
          if (imem_rvalid) begin
            req_addr_d = target;
          end else begin
            // Reply for the old address is still coming; it must be dropped.
            state_d = StDrop;
          end
        end else if (imem_rvalid) begin
          ibuf_d       = imem_rdata;
          ibuf_pc_d    = req_addr_q;
          ibuf_valid_d = 1'b1;
          pc_d         = req_addr_q + PcStep;
          state_d      = StFull;
        end
      end
      StFull: begin
        if (br_taken) begin
          ibuf_valid_d = 1'b0;
          pc_d         = target;
          req_addr_d   = target;
          state_d      = StWait;
        end else if (ibuf_valid_q && !freeze) begin
          ibuf_valid_d = 1'b0;
          req_addr_d   = pc_q;
          state_d      = StWait;
        end
      end
      StDrop: begin
        if (br_taken) begin
          ibuf_valid_d = 1'b0;
          pc_d         = target;
        end
        if (imem_rvalid) begin
          // Latest redirect wins: a same-cycle branch overrides the stored PC.
          req_addr_d = br_taken ? target : pc_q;
          state_d    = StWait;
        end
      end
      default: begin
        state_d = StWait;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StWait;
      pc_q         <= ResetPc;
      req_addr_q   <= ResetPc;
      ibuf_q       <= NOP_IR;
      ibuf_pc_q    <= ResetPc;
      ibuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ibuf_q       <= ibuf_d;
      ibuf_pc_q    <= ibuf_pc_d;
      ibuf_valid_q <= ibuf_valid_d;
    end
  end

  // rst gates the request so it drops the instant reset is asserted.
  assign imem_req  = rst && (state_q != StFull);
  assign imem_addr = req_addr_q;
  assign pc_out    = ibuf_pc_q;
  assign pc2_out   = ibuf_pc_q + PcStep;
  assign IR_out    = ibuf_valid_q ? ibuf_q : NOP_IR;
  assign if_valid  = ibuf_valid_q;

endmodule
